// File: rtl/fitness_feeder_if.sv
// Population-RAM read port and fitness-evaluator write/stream port, as seen from the feeder.
interface fitness_feeder_if #(
    parameter int DATA_WIDTH        = 4,
    parameter int INDIVIDUAL_LENGTH = 22,
    parameter int IDX_WIDTH         = 8
);
    logic                         pop_rd_en_o;
    logic [IDX_WIDTH-1:0]         pop_rd_addr_o;
    logic [INDIVIDUAL_LENGTH-1:0] pop_rd_data_i;
    logic                         wr_self_energy_valid_o;
    logic [DATA_WIDTH-1:0]        self_energy_o;
    logic                         wr_interact_valid_o;
    logic [DATA_WIDTH-1:0]        interact_energy_o;
    logic                         in_valid_o;
    logic [INDIVIDUAL_LENGTH-1:0] individual_vec_o;
    logic [IDX_WIDTH-1:0]         ind_idx_o;
    logic                         eval_out_valid_i;

    modport master (
        output pop_rd_en_o, pop_rd_addr_o,
        output wr_self_energy_valid_o, self_energy_o,
        output wr_interact_valid_o, interact_energy_o,
        output in_valid_o, individual_vec_o, ind_idx_o,
        input  pop_rd_data_i, eval_out_valid_i
    );

    modport slave (
        input  pop_rd_en_o, pop_rd_addr_o,
        input  wr_self_energy_valid_o, self_energy_o,
        input  wr_interact_valid_o, interact_energy_o,
        input  in_valid_o, individual_vec_o, ind_idx_o,
        output pop_rd_data_i, eval_out_valid_i
    );
endinterface

// File: rtl/fitness_feeder.sv
// Loads evaluator energy tables, streams the population with index tags, and
// signals done once every individual has been scored.
//   state   | meaning
//   IDLE    | waiting for start_i
//   LOAD_SE | writing self-energy entries 0..N-1
//   LOAD_IE | writing interaction entries row-major 0..N*N-1
//   STREAM  | one population read per cycle, addr 0..POP_SIZE-1
//   DRAIN   | all reads issued, waiting for remaining results
module fitness_feeder #(
    parameter int NUM_PARTICLE_TYPE = 3,
    parameter int DATA_WIDTH        = 4,
    parameter int PARTICLE_LENGTH   = 2,
    parameter int LATTICE_LENGTH    = 11,
    parameter int INDIVIDUAL_LENGTH = LATTICE_LENGTH * PARTICLE_LENGTH,
    parameter int POP_SIZE          = 50,
    parameter int IDX_WIDTH         = 8
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_n,
    input  logic                                                  start_i,
    input  logic                                                  cfg_skip_i,
    input  logic                                                  abort_i,
    input  logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]               self_energy_vec_i,
    input  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] interact_matrix_i,
    fitness_feeder_if.master                                      bus,
    output logic                                                  busy_o,
    output logic                                                  done_o
);
    localparam int SE_W = NUM_PARTICLE_TYPE * DATA_WIDTH;
    localparam int IE_W = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE * DATA_WIDTH;
    localparam logic [IDX_WIDTH-1:0] SE_LAST  = IDX_WIDTH'(NUM_PARTICLE_TYPE - 1);
    localparam logic [IDX_WIDTH-1:0] IE_LAST  = IDX_WIDTH'(NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE - 1);
    localparam logic [IDX_WIDTH-1:0] ADR_LAST = IDX_WIDTH'(POP_SIZE - 1);
    localparam logic [IDX_WIDTH:0]   RES_FULL = (IDX_WIDTH + 1)'(POP_SIZE);

    typedef enum logic [2:0] {IDLE, LOAD_SE, LOAD_IE, STREAM, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_WIDTH:0]     res_q, res_d;
    logic [SE_W-1:0]        se_q, se_d;
    logic [IE_W-1:0]        ie_q, ie_d;
    logic                   done_d;
    logic                   rd_pend_q;
    logic [IDX_WIDTH-1:0]   rd_addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        se_d    = se_q;
        ie_d    = ie_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                se_d    = self_energy_vec_i;
                ie_d    = interact_matrix_i;
                cnt_d   = '0;
                res_d   = '0;
                state_d = cfg_skip_i ? STREAM : LOAD_SE;
            end
            LOAD_SE: if (cnt_q == SE_LAST) begin
                state_d = LOAD_IE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + IDX_WIDTH'(1);
            end
            LOAD_IE: if (cnt_q == IE_LAST) begin
                state_d = STREAM;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + IDX_WIDTH'(1);
            end
            STREAM: if (cnt_q == ADR_LAST) begin
                state_d = DRAIN;
            end else begin
                cnt_d = cnt_q + IDX_WIDTH'(1);
            end
            DRAIN:   ;
            default: state_d = IDLE;
        endcase
        // Results may land in any busy state; the last one ends the run wherever we are.
        if (state_q != IDLE && bus.eval_out_valid_i) begin
            res_d = res_q + (IDX_WIDTH + 1)'(1);
            if (res_d == RES_FULL) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = cnt_q;
            res_d   = res_q;
            se_d    = se_q;
            ie_d    = ie_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q                    <= IDLE;
            cnt_q                      <= '0;
            res_q                      <= '0;
            se_q                       <= '0;
            ie_q                       <= '0;
            rd_pend_q                  <= 1'b0;
            rd_addr_q                  <= '0;
            busy_o                     <= 1'b0;
            done_o                     <= 1'b0;
            bus.wr_self_energy_valid_o <= 1'b0;
            bus.self_energy_o          <= '0;
            bus.wr_interact_valid_o    <= 1'b0;
            bus.interact_energy_o      <= '0;
            bus.pop_rd_en_o            <= 1'b0;
            bus.pop_rd_addr_o          <= '0;
            bus.in_valid_o             <= 1'b0;
            bus.individual_vec_o       <= '0;
            bus.ind_idx_o              <= '0;
        end else begin
            state_q                    <= state_d;
            cnt_q                      <= cnt_d;
            res_q                      <= res_d;
            se_q                       <= se_d;
            ie_q                       <= ie_d;
            busy_o                     <= (state_d != IDLE);
            done_o                     <= done_d;
            bus.wr_self_energy_valid_o <= (state_d == LOAD_SE);
            bus.self_energy_o          <= (state_d == LOAD_SE) ?
                                          DATA_WIDTH'(se_d >> (cnt_d * DATA_WIDTH)) : '0;
            bus.wr_interact_valid_o    <= (state_d == LOAD_IE);
            bus.interact_energy_o      <= (state_d == LOAD_IE) ?
                                          DATA_WIDTH'(ie_d >> (cnt_d * DATA_WIDTH)) : '0;
            bus.pop_rd_en_o            <= (state_d == STREAM);
            bus.pop_rd_addr_o          <= (state_d == STREAM) ? cnt_d : '0;
            // RAM data lands one cycle after the read; dropping to IDLE discards it.
            rd_pend_q                  <= bus.pop_rd_en_o && (state_d != IDLE);
            rd_addr_q                  <= bus.pop_rd_addr_o;
            bus.in_valid_o             <= rd_pend_q && (state_d != IDLE);
            bus.individual_vec_o       <= (rd_pend_q && state_d != IDLE) ? bus.pop_rd_data_i : '0;
            bus.ind_idx_o              <= (rd_pend_q && state_d != IDLE) ? rd_addr_q : '0;
        end
    end
endmodule

// File: tb/tb_fitness_feeder.sv
// Self-checking bench: cycle-accurate expectations derived from the start-relative
// schedule of table writes, reads and tagged individuals, with a randomised evaluator.
module tb_fitness_feeder;
    localparam int N = 3, DW = 4, IL = 22, POP = 50, IW = 8;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0, cfg_skip_i = 1'b0, abort_i = 1'b0;
    logic [N*DW-1:0]   se_vec = '0;
    logic [N*N*DW-1:0] ie_mat = '0;
    logic busy_o, done_o;
    logic [IL-1:0] ram [POP];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    fitness_feeder_if #(.DATA_WIDTH(DW), .INDIVIDUAL_LENGTH(IL), .IDX_WIDTH(IW)) bus ();

    fitness_feeder #(
        .NUM_PARTICLE_TYPE(N), .DATA_WIDTH(DW), .PARTICLE_LENGTH(2), .LATTICE_LENGTH(11),
        .INDIVIDUAL_LENGTH(IL), .POP_SIZE(POP), .IDX_WIDTH(IW)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .cfg_skip_i(cfg_skip_i),
        .abort_i(abort_i), .self_energy_vec_i(se_vec), .interact_matrix_i(ie_mat),
        .bus(bus), .busy_o(busy_o), .done_o(done_o)
    );

    always @(posedge clk_i)
        if (bus.pop_rd_en_o && bus.pop_rd_addr_o < IW'(POP))
            bus.pop_rd_data_i <= ram[bus.pop_rd_addr_o];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One start-to-completion sequence. abort_at / restart_at < 0 disables them.
    task automatic run(input bit skip, input bit fast, input int abort_at, input int restart_at,
                       input logic [N*DW-1:0] se, input logic [N*N*DW-1:0] ie);
        int t, base, done_t, pend, got, idx;
        bit ended, finished, e_se, e_ie, e_rd, e_iv, pulse;
        t = 0; done_t = -1; pend = 0; got = 0; finished = 0;
        base = skip ? 1 : 1 + N + N*N;
        start_i = 1'b1; cfg_skip_i = skip; se_vec = se; ie_mat = ie;
        bus.eval_out_valid_i = 1'b0;
        while (t < 300) begin
            @(posedge clk_i); @(negedge clk_i); t++;
            start_i = 1'b0; abort_i = 1'b0; bus.eval_out_valid_i = 1'b0;
            ended = (done_t >= 0 && t >= done_t) || (abort_at >= 0 && t > abort_at);
            e_se = !ended && !skip && t >= 1 && t <= N;
            e_ie = !ended && !skip && t >= N + 1 && t <= N + N*N;
            e_rd = !ended && t >= base && t < base + POP;
            e_iv = !ended && t >= base + 2 && t < base + POP + 2;
            chk("se_valid", bus.wr_self_energy_valid_o, e_se);
            chk("ie_valid", bus.wr_interact_valid_o, e_ie);
            chk("rd_en", bus.pop_rd_en_o, e_rd);
            chk("in_valid", bus.in_valid_o, e_iv);
            chk("busy", busy_o, !ended);
            chk("done", done_o, t == done_t);
            if (e_se) chk("se_data", bus.self_energy_o, se[DW*(t-1) +: DW]);
            if (e_ie) chk("ie_data", bus.interact_energy_o, ie[DW*(t-N-1) +: DW]);
            if (e_rd) chk("rd_addr", bus.pop_rd_addr_o, t - base);
            idx = t - base - 2;
            chk("ind_idx", bus.ind_idx_o, e_iv ? idx : 0);
            chk("ind_vec", bus.individual_vec_o, e_iv ? ram[idx] : '0);
            if (done_t >= 0 && t >= done_t + 2) begin finished = 1; break; end
            if (abort_at >= 0 && t >= abort_at + 5) begin finished = 1; break; end
            // drive inputs for cycle t
            if (t == abort_at) abort_i = 1'b1;
            if (t == restart_at) begin
                start_i = 1'b1; cfg_skip_i = ~skip; se_vec = ~se; ie_mat = ~ie;
            end
            if (e_iv) pend++;
            pulse = !ended && pend > 0 && (abort_at < 0 || t < abort_at) &&
                    (fast || $urandom_range(0, 1) == 0);
            if (pulse) begin
                bus.eval_out_valid_i = 1'b1;
                pend--; got++;
                if (got == POP) done_t = t + 1;
            end
        end
        chk("run_complete", finished, 1'b1);
    endtask

    initial begin
        bus.eval_out_valid_i = 1'b0;
        bus.pop_rd_data_i = '0;
        for (int k = 0; k < POP; k++) ram[k] = IL'(k);
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_rd_en", bus.pop_rd_en_o, 1'b0);
        chk("rst_in_valid", bus.in_valid_o, 1'b0);
        chk("rst_se_valid", bus.wr_self_energy_valid_o, 1'b0);
        chk("rst_ie_valid", bus.wr_interact_valid_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk_i);

        // full load, results returned in the same cycle as each individual
        run(1'b0, 1'b1, -1, -1, {4'd3, 4'd2, 4'd1},
            {4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1});

        // results while idle must neither count nor complete
        repeat (5) begin
            bus.eval_out_valid_i = 1'b1;
            @(posedge clk_i); @(negedge clk_i);
            chk("idle_done", done_o, 1'b0);
            chk("idle_busy", busy_o, 1'b0);
        end
        bus.eval_out_valid_i = 1'b0;

        for (int k = 0; k < POP; k++) ram[k] = IL'($urandom);
        run(1'b1, 1'b0, -1, -1, N*DW'($urandom), N*N*DW'({$urandom, $urandom}));
        run(1'b0, 1'b0, 30, -1, N*DW'($urandom), N*N*DW'({$urandom, $urandom}));
        run(1'b0, 1'b1, -1, -1, N*DW'($urandom), N*N*DW'({$urandom, $urandom}));
        run(1'b0, 1'b0, -1, 20, N*DW'($urandom), N*N*DW'({$urandom, $urandom}));

        // asynchronous reset in the middle of streaming
        start_i = 1'b1; cfg_skip_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("pre_rst_busy", busy_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", busy_o, 1'b0);
        chk("async_rd_en", bus.pop_rd_en_o, 1'b0);
        chk("async_in_valid", bus.in_valid_o, 1'b0);
        chk("async_done", done_o, 1'b0);
        @(negedge clk_i);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("post_rst_busy", busy_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
